lutram_mp: RTL and testbench
============================

Name: lutram_mp

Overview:
Parametrised multi-read-port distributed RAM (LUTRAM), the successor to the single-port `lutram`.
- One write port with byte enables.
- `NUM_RD_PORTS` independent read ports.
- Selectable combinational or registered read.
- Selectable read-first or write-first collision behaviour.
- Built-in clear sequencer that sweeps the array to `INIT_VALUE` after reset or on request.

Used as a register-file and small-table store in lab datapaths.

Parameters:
- RAM_WIDTH, 16, data word width in bits; must be a multiple of BYTE_W.
- RAM_ADDR_BITS, 3, address width; RAM_DEPTH = 2**RAM_ADDR_BITS.
- NUM_RD_PORTS, 2, number of read ports, 1..8.
- BYTE_W, 8, byte-enable granularity; NUM_BE = RAM_WIDTH/BYTE_W.
- READ_REG, 0, 0 = combinational read, 1 = read data registered on posedge clk_i.
- WRITE_FIRST, 1, 1 = same-cycle write to the read address is bypassed to rdata_o, 0 = old data returned.
- INIT_VALUE, '0, RAM_WIDTH-bit value written by the clear sweep.

Ports:
- clk_i, in, 1, clock; all state updates on posedge.
- rst_ni, in, 1, asynchronous active-low reset.
- we_i, in, 1, write request.
- wbe_i, in, NUM_BE, byte enables; bit k covers wdata_i[k*BYTE_W +: BYTE_W].
- waddr_i, in, RAM_ADDR_BITS, write address.
- wdata_i, in, RAM_WIDTH, write data.
- raddr_i, in, NUM_RD_PORTS x RAM_ADDR_BITS, read addresses, unpacked array.
- rdata_o, out, NUM_RD_PORTS x RAM_WIDTH, read data, unpacked array.
- clear_i, in, 1, single-cycle request to re-initialise the whole array.
- busy_o, out, 1, clear sweep in progress; user writes are ignored while high.

Behaviour:
- The storage array has no reset. Its contents are defined only by the clear sweep and by writes.

Clear FSM, states IDLE and CLEAR, with counter cnt of RAM_ADDR_BITS bits:
- rst_ni low: state = CLEAR and cnt = 0 asynchronously; busy_o = 1.
- In CLEAR, each posedge writes INIT_VALUE (all bytes) to mem[cnt]. If cnt == RAM_DEPTH-1, go to IDLE; otherwise cnt++.
- busy_o is therefore high for exactly RAM_DEPTH posedges after reset release.
- In IDLE, clear_i = 1 at a posedge causes cnt = 0 and state = CLEAR. The first clear write happens on the following posedge, so busy_o is high for RAM_DEPTH cycles.
- clear_i while in CLEAR is ignored; the sweep does not restart.
- Reset asserted mid-sweep aborts the sweep; a full sweep restarts after release.

User write:
- Applies only when we_i = 1 and busy_o = 0 at the posedge.
- For each k with wbe_i[k] = 1, byte k of mem[waddr_i] takes byte k of wdata_i. Other bytes are unchanged.
- we_i with wbe_i = 0 is a no-op.
- During busy_o, we_i is dropped silently; it is not queued.

Read, READ_REG = 0:
- rdata_o[p] = mem[raddr_i[p]] combinationally.
- If WRITE_FIRST = 1 and an accepted write has waddr_i == raddr_i[p] in the same cycle, rdata_o[p] = byte-merged(mem, wdata_i, wbe_i) before the edge.
- If WRITE_FIRST = 0, the old word is returned until the edge.

Read, READ_REG = 1:
- rdata_o[p] is registered at posedge with 1-cycle latency.
- The captured value is the merged new word if WRITE_FIRST = 1, otherwise the old word.
- Registers reset asynchronously to INIT_VALUE.

While busy_o = 1:
- Every rdata_o[p] reads INIT_VALUE, in combinational mode immediately, in registered mode at the next edge.

Other rules:
- Multiple read ports on the same address return identical data.
- Addresses are always in range (full power-of-two depth), so no wrap or out-of-range handling is needed.

Decomposition:
- Package lutram_pkg holds the clear FSM state enum (IDLE, CLEAR), the function merge_bytes(old, new, be) parametrised by BYTE_W, and the elaboration-time width check (RAM_WIDTH % BYTE_W == 0).
- Sub-module lutram_clear_fsm: the state register, cnt, busy_o, and clear address/data/enable outputs.
- The top level muxes the clear write against the user write, and contains the read ports and optional output registers.

Test Plan:
Default parameters (16/3/2, READ_REG=0, WRITE_FIRST=1) unless stated.
1. Release rst_ni. Required: busy_o high for exactly 8 posedges, then low. All 8 addresses read 0x0000 on both ports. rdata_o = 0x0000 throughout busy.
2. Write 0xA5C3 to addr 5 with wbe=2'b11. Next cycle set raddr[0]=5 and raddr[1]=5. Required: both ports read 0xA5C3. Then write 0x1234 to addr 5 with wbe=2'b01. Required: reads 0xA534.
3. Write 0xBEEF to addr 2 with raddr[1]=2 in the same cycle (old value 0x0000). Required: WRITE_FIRST=1 gives 0xBEEF before the edge; WRITE_FIRST=0 gives 0x0000 until the edge, then 0xBEEF.
4. READ_REG=1: raddr[0]=5 changes at cycle N. Required: rdata_o[0] updates at posedge N+1. Reset mid-operation: rdata_o = 0x0000 immediately.
5. Fill all 8 addresses, pulse clear_i, and during busy write 0x1111 to addr 3 and pulse clear_i again. Required: busy_o high for 8 cycles and not extended. Afterwards all addresses read 0x0000, including addr 3.
6. Assert rst_ni low when cnt = 4 during a sweep, then release. Required: busy_o high for a full 8 cycles after release, and all addresses read 0x0000 afterwards.

Source files
------------

// File: rtl/lutram_pkg.sv
// Shared types and helpers for the multi-read-port LUTRAM.
//   clr_state_e : clear sequencer states
//   merge_bytes : byte-enable merge of a new word over an old word
//   width_ok    : elaboration-time check that the word is a whole number of bytes
package lutram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Widest word merge_bytes can handle; callers zero-extend into it and
  // truncate the result back to their own width.
  localparam int unsigned MERGE_MAX_W = 256;

  // Bit i of the result comes from new_w when the enable of the byte that
  // holds it (i / byte_w) is set, otherwise from old_w.
  function automatic logic [MERGE_MAX_W-1:0] merge_bytes(
    input logic [MERGE_MAX_W-1:0] old_w,
    input logic [MERGE_MAX_W-1:0] new_w,
    input logic [MERGE_MAX_W-1:0] be,
    input int unsigned            byte_w
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_w;
    for (int unsigned i = 0; i < MERGE_MAX_W; i++) begin
      if (be[i / byte_w]) res[i] = new_w[i];
    end
    return res;
  endfunction

  function automatic bit width_ok(input int unsigned w, input int unsigned bw);
    return (bw != 0) && (w <= MERGE_MAX_W) && ((w % bw) == 0);
  endfunction

endpackage

// File: rtl/lutram_clear_fsm.sv
// Clear sequencer: sweeps every address with INIT_VALUE after reset and on
// a clear_i pulse while idle.
//   clk_i, rst_ni : clock, async active-low reset (reset starts a sweep)
//   clear_i       : single-cycle request, ignored while a sweep is running
//   busy_o        : sweep in progress
//   clr_we_o      : write strobe for the sweep
//   clr_addr_o    : address being cleared this cycle
//   clr_data_o    : value written by the sweep
module lutram_clear_fsm
  import lutram_pkg::*;
#(
  parameter int                ADDR_BITS  = 3,
  parameter int                WIDTH      = 16,
  parameter logic [WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  output logic                 busy_o,
  output logic                 clr_we_o,
  output logic [ADDR_BITS-1:0] clr_addr_o,
  output logic [WIDTH-1:0]     clr_data_o
);

  // Depth is a full power of two, so the last address is all ones.
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  clr_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        // The write to mem[cnt_q] happens on this same edge.
        if (cnt_q == LAST_ADDR) state_d = IDLE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q == CLEAR);
  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = cnt_q;
  assign clr_data_o = INIT_VALUE;

endmodule

// File: rtl/lutram_mp.sv
// Multi-read-port distributed RAM with one byte-enabled write port.
//   clk_i, rst_ni : clock, async active-low reset (starts a clear sweep)
//   we_i, wbe_i   : write request and byte enables
//   waddr_i/wdata_i : write address and data
//   raddr_i[p]    : read address of port p
//   rdata_o[p]    : read data of port p (combinational or registered)
//   clear_i       : request a full re-initialise to INIT_VALUE
//   busy_o        : clear sweep running; user writes are dropped
module lutram_mp
  import lutram_pkg::*;
#(
  parameter int                    RAM_WIDTH     = 16,
  parameter int                    RAM_ADDR_BITS = 3,
  parameter int                    NUM_RD_PORTS  = 2,
  parameter int                    BYTE_W        = 8,
  parameter int                    READ_REG      = 0,
  parameter int                    WRITE_FIRST   = 1,
  parameter logic [RAM_WIDTH-1:0]  INIT_VALUE    = '0,
  localparam int                   NUM_BE        = RAM_WIDTH / BYTE_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [NUM_BE-1:0]        wbe_i,
  input  logic [RAM_ADDR_BITS-1:0] waddr_i,
  input  logic [RAM_WIDTH-1:0]     wdata_i,
  input  logic [RAM_ADDR_BITS-1:0] raddr_i [NUM_RD_PORTS],
  output logic [RAM_WIDTH-1:0]     rdata_o [NUM_RD_PORTS],
  input  logic                     clear_i,
  output logic                     busy_o
);

  localparam int RAM_DEPTH = 2 ** RAM_ADDR_BITS;

  if (!width_ok(RAM_WIDTH, BYTE_W)) begin : g_bad_width
    $error("lutram_mp: RAM_WIDTH must be a multiple of BYTE_W");
  end
  if (NUM_RD_PORTS < 1 || NUM_RD_PORTS > 8) begin : g_bad_ports
    $error("lutram_mp: NUM_RD_PORTS must be 1..8");
  end

  logic                     busy;
  logic                     clr_we;
  logic [RAM_ADDR_BITS-1:0] clr_addr;
  logic [RAM_WIDTH-1:0]     clr_data;

  lutram_clear_fsm #(
    .ADDR_BITS  (RAM_ADDR_BITS),
    .WIDTH      (RAM_WIDTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_clr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .clr_data_o (clr_data)
  );

  assign busy_o = busy;

  // Storage has no reset; the sweep defines its contents.
  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  // A write with no byte enables would rewrite the old word; skip it.
  logic                 wr_acc;
  logic [RAM_WIDTH-1:0] wr_word;

  assign wr_acc  = we_i && !busy && (|wbe_i);
  assign wr_word = RAM_WIDTH'(merge_bytes(MERGE_MAX_W'(mem[waddr_i]),
                                          MERGE_MAX_W'(wdata_i),
                                          MERGE_MAX_W'(wbe_i),
                                          BYTE_W));

  always_ff @(posedge clk_i) begin
    if (clr_we)      mem[clr_addr] <= clr_data;
    else if (wr_acc) mem[waddr_i]  <= wr_word;
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic                 hit;
    logic [RAM_WIDTH-1:0] word;

    // Bypass only in write-first mode; read-first sees the array as it is.
    assign hit = (WRITE_FIRST != 0) && wr_acc && (waddr_i == raddr_i[p]);

    always_comb begin
      word = mem[raddr_i[p]];
      if (busy)     word = INIT_VALUE;
      else if (hit) word = wr_word;
    end

    if (READ_REG != 0) begin : g_reg
      logic [RAM_WIDTH-1:0] rd_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rd_q <= INIT_VALUE;
        else         rd_q <= word;
      end
      assign rdata_o[p] = rd_q;
    end else begin : g_comb
      assign rdata_o[p] = word;
    end
  end

endmodule

// File: tb/tb_lutram_mp.sv
module tb_lutram_mp;
  localparam int W = 16;
  localparam int A = 3;
  localparam int P = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic          clr = 1'b0;
  logic [1:0]    wbe = '0;
  logic [A-1:0]  waddr = '0;
  logic [W-1:0]  wdata = '0;
  logic [A-1:0]  raddr [P];
  logic [W-1:0]  rd_a [P];   // comb, write-first
  logic [W-1:0]  rd_b [P];   // comb, read-first
  logic [W-1:0]  rd_c [P];   // registered, write-first
  logic          busy_a, busy_b, busy_c;

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  sb_q [$];

  always #5 clk = ~clk;

  lutram_mp #(.READ_REG(0), .WRITE_FIRST(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we), .wbe_i(wbe), .waddr_i(waddr),
    .wdata_i(wdata), .raddr_i(raddr), .rdata_o(rd_a), .clear_i(clr), .busy_o(busy_a));
  lutram_mp #(.READ_REG(0), .WRITE_FIRST(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we), .wbe_i(wbe), .waddr_i(waddr),
    .wdata_i(wdata), .raddr_i(raddr), .rdata_o(rd_b), .clear_i(clr), .busy_o(busy_b));
  lutram_mp #(.READ_REG(1), .WRITE_FIRST(1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we), .wbe_i(wbe), .waddr_i(waddr),
    .wdata_i(wdata), .raddr_i(raddr), .rdata_o(rd_c), .clear_i(clr), .busy_o(busy_c));

  typedef struct {
    logic         we;
    logic [1:0]   wbe;
    logic [A-1:0] waddr;
    logic [W-1:0] wdata;
    logic [A-1:0] ra0, ra1;
    logic [W-1:0] e0, e1;   // write-first, before the edge
    logic [W-1:0] o0, o1;   // read-first, before the edge
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic sb_pop_chk(input string nm, input logic [W-1:0] act);
    logic [W-1:0] exp;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty got=%h", nm, act);
    end else begin
      exp = sb_q.pop_front();
      chk(nm, act, exp);
    end
  endtask

  // Called just after a negedge with a sweep already running. Counts the
  // negedges at which busy is high; optionally pokes a write and a second
  // clear into the sweep.
  task automatic measure_busy(input bit poke, input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_a !== 1'b1) break;
      n++;
      chk({tag, "_busy_rd0"}, rd_a[0], 0);
      chk({tag, "_busy_rd1"}, rd_a[1], 0);
      if (poke && n == 2) begin
        we = 1'b1; wbe = 2'b11; waddr = 3'd3; wdata = 16'h1111; clr = 1'b1;
      end
      if (poke && n == 3) begin
        we = 1'b0; clr = 1'b0;
      end
      @(negedge clk);
      #1;
    end
    we = 1'b0; clr = 1'b0;
    chk({tag, "_busy_len"}, n, 8);
    chk({tag, "_busy_c_done"}, busy_c, 1'b0);
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      raddr[0] = A'(a);
      raddr[1] = A'(7 - a);
      #1;
      chk($sformatf("%s_a%0d_p0", tag, a), rd_a[0], 0);
      chk($sformatf("%s_a%0d_p1", tag, a), rd_a[1], 0);
      chk($sformatf("%s_a%0d_rf", tag, a), rd_b[0], 0);
    end
  endtask

  task automatic fill();
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      we = 1'b1; wbe = 2'b11; waddr = A'(a); wdata = 16'h1011 + 16'(a);
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    raddr[0] = '0;
    raddr[1] = '0;
    //            we    wbe    addr  wdata     ra0   ra1   e0        e1        o0        o1
    vecs[0] = '{1'b1, 2'b11, 3'd5, 16'hA5C3, 3'd0, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 2'b00, 3'd0, 16'h0000, 3'd5, 3'd5, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3};
    vecs[2] = '{1'b1, 2'b01, 3'd5, 16'h1234, 3'd5, 3'd5, 16'hA534, 16'hA534, 16'hA5C3, 16'hA5C3};
    vecs[3] = '{1'b0, 2'b00, 3'd0, 16'h0000, 3'd5, 3'd5, 16'hA534, 16'hA534, 16'hA534, 16'hA534};
    vecs[4] = '{1'b1, 2'b11, 3'd2, 16'hBEEF, 3'd5, 3'd2, 16'hA534, 16'hBEEF, 16'hA534, 16'h0000};
    vecs[5] = '{1'b0, 2'b00, 3'd0, 16'h0000, 3'd2, 3'd2, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    vecs[6] = '{1'b1, 2'b10, 3'd7, 16'h12FF, 3'd7, 3'd2, 16'h1200, 16'hBEEF, 16'h0000, 16'hBEEF};
    vecs[7] = '{1'b1, 2'b00, 3'd2, 16'hFFFF, 3'd2, 3'd7, 16'hBEEF, 16'h1200, 16'hBEEF, 16'h1200};
    vecs[8] = '{1'b0, 2'b00, 3'd0, 16'h0000, 3'd7, 3'd0, 16'h1200, 16'h0000, 16'h1200, 16'h0000};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy_a, 1'b1);
    chk("rst_rd_comb", rd_a[0], 0);
    chk("rst_rd_reg", rd_c[0], 0);

    // 1: sweep after reset release
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    measure_busy(1'b0, "t1");
    read_all_zero("t1_rd");

    // 2/3: table of writes and reads; registered copy via scoreboard
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      we = vecs[i].we; wbe = vecs[i].wbe; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      raddr[0] = vecs[i].ra0; raddr[1] = vecs[i].ra1;
      #1;
      chk($sformatf("v%0d_wf_p0", i), rd_a[0], vecs[i].e0);
      chk($sformatf("v%0d_wf_p1", i), rd_a[1], vecs[i].e1);
      chk($sformatf("v%0d_rf_p0", i), rd_b[0], vecs[i].o0);
      chk($sformatf("v%0d_rf_p1", i), rd_b[1], vecs[i].o1);
      sb_q.push_back(vecs[i].e0);
      sb_q.push_back(vecs[i].e1);
      @(posedge clk);
      #1;
      sb_pop_chk($sformatf("v%0d_reg_p0", i), rd_c[0]);
      sb_pop_chk($sformatf("v%0d_reg_p1", i), rd_c[1]);
    end

    // 4: registered latency, then async reset of the output registers
    @(negedge clk);
    we = 1'b0; raddr[0] = 3'd5; raddr[1] = 3'd7;
    #1;
    chk("t4_hold", rd_c[0], 16'h1200);
    chk("t4_comb", rd_a[0], 16'hA534);
    @(posedge clk);
    #1;
    chk("t4_upd_p0", rd_c[0], 16'hA534);
    chk("t4_upd_p1", rd_c[1], 16'h1200);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_p0", rd_c[0], 0);
    chk("t4_rst_p1", rd_c[1], 0);
    chk("t4_rst_busy", busy_a, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    measure_busy(1'b0, "t4");
    read_all_zero("t4_rd");

    // 5: fill, clear, poke a write and a second clear mid-sweep
    fill();
    raddr[0] = 3'd3; raddr[1] = 3'd6;
    #1;
    chk("t5_fill_p0", rd_a[0], 16'h1014);
    chk("t5_fill_p1", rd_a[1], 16'h1017);
    pulse_clear();
    measure_busy(1'b1, "t5");
    read_all_zero("t5_rd");
    chk("t5_idle", busy_a, 1'b0);

    // 6: reset at cnt == 4 mid-sweep, full sweep after release
    fill();
    pulse_clear();
    repeat (4) @(negedge clk);
    #1;
    chk("t6_busy_mid", busy_a, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    measure_busy(1'b0, "t6");
    read_all_zero("t6_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
